// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: PC generator state encoding and the
// default reset / exception vectors reused by the control unit.
package mips_pkg;

  typedef enum logic [1:0] {
    PCG_RUN       = 2'd0,
    PCG_HOLD      = 2'd1,
    PCG_HOLD_PEND = 2'd2
  } pcg_state_e;

  localparam logic [31:0] PCG_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PCG_EXC_VEC   = 32'h8000_0180;

endpackage

// File: rtl/pc_gen_reg.sv
// WIDTH-wide load-enabled register with asynchronous active-high reset to RST_VAL.
module pc_gen_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_q <= RST_VAL;
    else if (i_ld)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage program counter: sequential step, redirect, exception vector,
// stall hold with capture of a redirect that arrives while stalled.
module pc_gen_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter logic [31:0] RESET_VEC  = PCG_RESET_VEC,
  parameter logic [31:0] EXC_VEC    = PCG_EXC_VEC,
  parameter int unsigned STEP       = 4,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pend_valid,
  output logic             misalign_err
);

  localparam logic [WIDTH-1:0] RESET_W    = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_W      = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  // Zero mask when ALIGN_BITS is 0, which disables the check without a negative slice.
  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  pcg_state_e       r_state;
  pcg_state_e       w_state_nxt;
  logic             r_misalign;
  logic             w_misalign_nxt;
  logic [WIDTH-1:0] w_pc;
  logic [WIDTH-1:0] w_pend;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_pc_ld;
  logic             w_pend_ld;
  logic             w_tgt_bad;
  logic [WIDTH-1:0] w_tgt_chk;

  assign w_tgt_bad = |(redirect_target & ALIGN_MASK);
  assign w_tgt_chk = w_tgt_bad ? EXC_W : redirect_target;

  pc_gen_reg #(.WIDTH(WIDTH), .RST_VAL(RESET_W)) u_pc_reg (
    .i_clk (clk),
    .i_rst (reset),
    .i_ld  (w_pc_ld),
    .i_d   (w_pc_nxt),
    .o_q   (w_pc)
  );

  pc_gen_reg #(.WIDTH(WIDTH), .RST_VAL(RESET_W)) u_pend_reg (
    .i_clk (clk),
    .i_rst (reset),
    .i_ld  (w_pend_ld),
    .i_d   (w_tgt_chk),
    .o_q   (w_pend)
  );

  always_comb begin
    w_pc_nxt       = w_pc + STEP_W;
    w_pc_ld        = 1'b1;
    w_pend_ld      = 1'b0;
    w_state_nxt    = PCG_RUN;
    w_misalign_nxt = 1'b0;
    if (exc_req) begin
      w_pc_nxt    = EXC_W;
      w_state_nxt = stall ? PCG_HOLD : PCG_RUN;
    end else if (stall) begin
      w_pc_ld = 1'b0;
      if (redirect_valid) begin
        w_pend_ld      = 1'b1;
        w_state_nxt    = PCG_HOLD_PEND;
        w_misalign_nxt = w_tgt_bad;
      end else begin
        w_state_nxt = (r_state == PCG_RUN) ? PCG_HOLD : r_state;
      end
    end else if (redirect_valid) begin
      w_pc_nxt       = w_tgt_chk;
      w_misalign_nxt = w_tgt_bad;
    end else if (r_state == PCG_HOLD_PEND) begin
      // Pending target was already alignment-checked when captured.
      w_pc_nxt = w_pend;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= PCG_RUN;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign pc_out       = w_pc;
  assign pc_plus_step = w_pc + STEP_W;
  assign pend_valid   = (r_state == PCG_HOLD_PEND);
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed-vector bench for pc_gen_unit with default parameters.
module tb_pc_gen_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_req;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_step;
  logic        pend_valid;
  logic        misalign_err;

  int n_vec = 0;
  int n_mis = 0;

  pc_gen_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .pc_out          (pc_out),
    .pc_plus_step    (pc_plus_step),
    .pend_valid      (pend_valid),
    .misalign_err    (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc,
                           input logic pend, input logic mis);
    chk({tag, "_pc"},   pc_out,       pc);
    chk({tag, "_ps"},   pc_plus_step, pc + 32'd4);
    chk({tag, "_pend"}, {31'd0, pend_valid},   {31'd0, pend});
    chk({tag, "_mis"},  {31'd0, misalign_err}, {31'd0, mis});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; exc_req = 1'b0;
    tick();
    tick();
    chk_state("rst", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    chk_state("rel", 32'h0, 1'b0, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_state("seq", 32'(i * 4), 1'b0, 1'b0);
    end

    redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
    tick();
    chk_state("redir", 32'h0040_0100, 1'b0, 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk_state("redir+", 32'h0040_0104, 1'b0, 1'b0);

    // Stall with two redirects: latest wins.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    chk_state("stl1", 32'h0040_0104, 1'b1, 1'b0);
    redirect_target = 32'h300;
    tick();
    chk_state("stl2", 32'h0040_0104, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk_state("stl3", 32'h0040_0104, 1'b1, 1'b0);
    stall = 1'b0;
    tick();
    chk_state("pendap", 32'h300, 1'b0, 1'b0);
    tick();
    chk_state("pendap+", 32'h304, 1'b0, 1'b0);

    redirect_valid = 1'b1; redirect_target = 32'h102;
    tick();
    chk_state("misal", 32'h8000_0180, 1'b0, 1'b1);
    redirect_valid = 1'b0;
    tick();
    chk_state("misal+", 32'h8000_0184, 1'b0, 1'b0);

    // Exception during stall clears the pending redirect and keeps holding.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    chk_state("exst0", 32'h8000_0184, 1'b1, 1'b0);
    redirect_valid = 1'b0; exc_req = 1'b1;
    tick();
    chk_state("exst1", 32'h8000_0180, 1'b0, 1'b0);
    exc_req = 1'b0;
    tick();
    chk_state("exst2", 32'h8000_0180, 1'b0, 1'b0);
    stall = 1'b0;
    tick();
    chk_state("exst3", 32'h8000_0184, 1'b0, 1'b0);

    exc_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h102;
    tick();
    chk_state("excmis", 32'h8000_0180, 1'b0, 1'b0);
    exc_req = 1'b0; redirect_valid = 1'b0;

    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    chk_state("wrap0", 32'hFFFF_FFFC, 1'b0, 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk_state("wrap1", 32'h0, 1'b0, 1'b0);

    // Misaligned target captured while stalled.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h201;
    tick();
    chk_state("mcap0", 32'h0, 1'b1, 1'b1);
    redirect_valid = 1'b0;
    tick();
    chk_state("mcap1", 32'h0, 1'b1, 1'b0);
    stall = 1'b0;
    tick();
    chk_state("mcap2", 32'h8000_0180, 1'b0, 1'b0);

    // Live redirect discards a pending one.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    chk_state("live0", 32'h8000_0180, 1'b1, 1'b0);
    stall = 1'b0; redirect_target = 32'h400;
    tick();
    chk_state("live1", 32'h400, 1'b0, 1'b0);
    redirect_valid = 1'b0;
    tick();
    chk_state("live2", 32'h404, 1'b0, 1'b0);

    // Asynchronous reset in the middle of HOLD_PEND.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    chk_state("ar0", 32'h404, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_state("ar1", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    chk_state("ar2", 32'h0, 1'b0, 1'b0);
    tick();
    chk_state("ar3", 32'h4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
